// File: rtl/ram_access_ctrl.sv
// Arbitrates instruction fetches and data loads/stores onto a single word-wide RAM port.
// Define HALFWORD_ACCESS_EN to accept halfword (d_sel = 0011) data accesses.
`timescale 1ns/1ps
module ram_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        d_error,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        stall_req
);

    typedef enum logic [1:0] {StIdle, StData, StFetch} state_e;

    state_e      state;
    logic        fetch_prio;
    logic        data_pending;
    logic        fetch_pending;
    logic        grant_fetch;
    logic        sel_ok;
    logic        d_illegal;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;
    logic        unused_if_addr;

    assign unused_if_addr = ^if_addr[1:0];

    // A requester still sees its own ready pulse for one cycle before dropping the request,
    // so that cycle must not be mistaken for a new request.
    assign data_pending  = (d_read | d_write) & ~d_ready;
    assign fetch_pending = if_req & ~if_ready;
    assign grant_fetch   = fetch_pending & (fetch_prio | ~data_pending);

    assign stall_req = ((d_read | d_write) & ~d_ready) | (if_req & ~if_ready);

    always_comb begin
        sel_ok     = 1'b0;
        lane_we    = 4'b0000;
        lane_wdata = 32'h0;
        case (d_sel)
            4'b0001: begin
                sel_ok     = 1'b1;
                lane_we    = 4'b0001 << d_addr[1:0];
                lane_wdata = {4{d_wdata[7:0]}};
            end
            4'b1111: begin
                sel_ok     = (d_addr[1:0] == 2'b00);
                lane_we    = 4'b1111;
                lane_wdata = d_wdata;
            end
`ifdef HALFWORD_ACCESS_EN
            4'b0011: begin
                sel_ok     = ~d_addr[0];
                lane_we    = 4'b0011 << d_addr[1:0];
                lane_wdata = {2{d_wdata[15:0]}};
            end
`endif
            default: sel_ok = 1'b0;
        endcase
        d_illegal = ~sel_ok | (d_read & d_write);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            fetch_prio <= 1'b0;
            if_rdata   <= 32'h0;
            if_ready   <= 1'b0;
            d_rdata    <= 32'h0;
            d_ready    <= 1'b0;
            d_error    <= 1'b0;
            ram_en     <= 1'b0;
            ram_we     <= 4'b0000;
            ram_addr   <= 32'h0;
            ram_wdata  <= 32'h0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            d_error  <= 1'b0;
            case (state)
                StIdle: begin
                    if (grant_fetch) begin
                        state      <= StFetch;
                        fetch_prio <= 1'b0;
                        ram_en     <= 1'b1;
                        ram_we     <= 4'b0000;
                        ram_addr   <= {if_addr[31:2], 2'b00};
                        ram_wdata  <= 32'h0;
                    end else if (data_pending) begin
                        if (d_illegal) begin
                            d_error <= 1'b1;
                            d_ready <= 1'b1;
                        end else begin
                            state     <= StData;
                            ram_en    <= 1'b1;
                            ram_we    <= d_write ? lane_we : 4'b0000;
                            ram_addr  <= {d_addr[31:2], 2'b00};
                            ram_wdata <= d_write ? lane_wdata : 32'h0;
                        end
                    end
                end
                StData: begin
                    if (ram_ack) begin
                        state      <= StIdle;
                        d_rdata    <= ram_rdata;
                        d_ready    <= 1'b1;
                        fetch_prio <= 1'b1;
                        ram_en     <= 1'b0;
                        ram_we     <= 4'b0000;
                    end
                end
                StFetch: begin
                    if (ram_ack) begin
                        state    <= StIdle;
                        if_rdata <= ram_rdata;
                        if_ready <= 1'b1;
                        ram_en   <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_error_with_ready: assert property (@(posedge clk) disable iff (!rst_n)
        d_error |-> d_ready);
    a_single_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_ready && if_ready));
    a_word_addr: assert property (@(posedge clk) disable iff (!rst_n)
        ram_addr[1:0] == 2'b00);
    a_hold_until_ack: assert property (@(posedge clk) disable iff (!rst_n)
        (ram_en && !ram_ack) |=> (ram_en && $stable(ram_addr) && $stable(ram_we)
                                  && $stable(ram_wdata)));
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl; honours HALFWORD_ACCESS_EN when defined.
`timescale 1ns/1ps
module tb_ram_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_read;
    logic        d_write;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        d_error;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        stall_req;

    int n_cmp = 0;
    int n_bad = 0;

    ram_access_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_sel     (d_sel),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .d_error   (d_error),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_sel = '0; d_addr = '0; d_wdata = '0; ram_rdata = '0; ram_ack = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if ({ram_en, ram_we, d_ready, d_error, if_ready} !== 8'h00) begin
            n_bad++; $display("FAIL reset_ctrl got %b want 0", {ram_en, ram_we, d_ready, d_error, if_ready});
        end
        n_cmp++; if ({ram_addr, ram_wdata, d_rdata, if_rdata} !== 128'h0) begin
            n_bad++; $display("FAIL reset_data got %h want 0", {ram_addr, ram_wdata, d_rdata, if_rdata});
        end
        n_cmp++; if (stall_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_stall got %b want 0", stall_req);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte_store();
        d_write = 1'b1; d_sel = 4'b0001; d_addr = 32'h0000_1002; d_wdata = 32'h0000_00AB;
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin
            n_bad++; $display("FAIL bs_stall got %b want 1", stall_req);
        end
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b1 || ram_addr !== 32'h0000_1000) begin
            n_bad++; $display("FAIL bs_grant got en=%b addr=%h want en=1 addr=00001000", ram_en, ram_addr);
        end
        n_cmp++; if (ram_we !== 4'b0100 || ram_wdata !== 32'hABAB_ABAB) begin
            n_bad++; $display("FAIL bs_lanes got we=%b wdata=%h want we=0100 wdata=abababab", ram_we, ram_wdata);
        end
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        n_cmp++; if (d_ready !== 1'b1 || d_error !== 1'b0 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL bs_ready got rdy=%b err=%b en=%b want 1 0 0", d_ready, d_error, ram_en);
        end
        d_write = 1'b0;
        @(negedge clk);
        n_cmp++; if (d_ready !== 1'b0 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL bs_once got rdy=%b en=%b want 0 0", d_ready, ram_en);
        end
    endtask

    task automatic test_word_load();
        d_read = 1'b1; d_sel = 4'b1111; d_addr = 32'h0000_2000;
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin
            n_bad++; $display("FAIL wl_stall_req got %b want 1", stall_req);
        end
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b1 || ram_we !== 4'b0000 || ram_addr !== 32'h0000_2000) begin
            n_bad++; $display("FAIL wl_grant got en=%b we=%b addr=%h want 1 0000 00002000", ram_en, ram_we, ram_addr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (ram_en !== 1'b1 || stall_req !== 1'b1 || d_ready !== 1'b0) begin
                n_bad++; $display("FAIL wl_wait got en=%b stall=%b rdy=%b want 1 1 0", ram_en, stall_req, d_ready);
            end
        end
        ram_rdata = 32'hDEAD_BEEF; ram_ack = 1'b1;
        #1;
        n_cmp++; if (stall_req !== 1'b1) begin
            n_bad++; $display("FAIL wl_stall_ack got %b want 1", stall_req);
        end
        @(negedge clk);
        ram_ack = 1'b0;
        n_cmp++; if (d_ready !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL wl_data got rdy=%b rdata=%h want 1 deadbeef", d_ready, d_rdata);
        end
        n_cmp++; if (stall_req !== 1'b0 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL wl_release got stall=%b en=%b want 0 0", stall_req, ram_en);
        end
        d_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle_ack();
        ram_rdata = 32'h1111_2222; ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        n_cmp++; if (d_ready !== 1'b0 || if_ready !== 1'b0 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL idle_ack got drdy=%b irdy=%b en=%b want 0 0 0", d_ready, if_ready, ram_en);
        end
        n_cmp++; if (d_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL idle_ack_rdata got %h want deadbeef", d_rdata);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  sels [3]  = '{4'b1111, 4'b0001, 4'b0101};
        logic [31:0] addrs [3] = '{32'h0000_3001, 32'h0000_3000, 32'h0000_3000};
        logic        both [3]  = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            d_write = 1'b1; d_read = both[i]; d_sel = sels[i]; d_addr = addrs[i];
            d_wdata = 32'h5555_AAAA;
            @(negedge clk);
            n_cmp++; if (d_error !== 1'b1 || d_ready !== 1'b1 || ram_en !== 1'b0) begin
                n_bad++; $display("FAIL illegal_%0d got err=%b rdy=%b en=%b want 1 1 0", i, d_error, d_ready, ram_en);
            end
            d_write = 1'b0; d_read = 1'b0;
            @(negedge clk);
            n_cmp++; if (d_error !== 1'b0 || d_ready !== 1'b0 || ram_en !== 1'b0) begin
                n_bad++; $display("FAIL illegal_%0d_after got err=%b rdy=%b en=%b want 0 0 0", i, d_error, d_ready, ram_en);
            end
        end
    endtask

    task automatic test_halfword();
        d_write = 1'b1; d_sel = 4'b0011; d_addr = 32'h0000_4002; d_wdata = 32'h0000_1234;
        @(negedge clk);
`ifdef HALFWORD_ACCESS_EN
        n_cmp++; if (ram_en !== 1'b1 || ram_we !== 4'b1100 || ram_wdata !== 32'h1234_1234) begin
            n_bad++; $display("FAIL half_grant got en=%b we=%b wdata=%h want 1 1100 12341234", ram_en, ram_we, ram_wdata);
        end
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        n_cmp++; if (d_ready !== 1'b1 || d_error !== 1'b0) begin
            n_bad++; $display("FAIL half_ready got rdy=%b err=%b want 1 0", d_ready, d_error);
        end
`else
        n_cmp++; if (d_error !== 1'b1 || d_ready !== 1'b1 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL half_error got err=%b rdy=%b en=%b want 1 1 0", d_error, d_ready, ram_en);
        end
`endif
        d_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        if_req = 1'b1; if_addr = 32'h0000_5007;
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b1 || ram_addr !== 32'h0000_5004 || ram_we !== 4'b0000) begin
            n_bad++; $display("FAIL fetch_grant got en=%b addr=%h we=%b want 1 00005004 0000", ram_en, ram_addr, ram_we);
        end
        ram_rdata = 32'h0040_0093; ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        n_cmp++; if (if_ready !== 1'b1 || if_rdata !== 32'h0040_0093 || d_ready !== 1'b0) begin
            n_bad++; $display("FAIL fetch_data got rdy=%b rdata=%h drdy=%b want 1 00400093 0", if_ready, if_rdata, d_ready);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        d_read = 1'b1; d_sel = 4'b1111; d_addr = 32'h0000_6000;
        if_req = 1'b1; if_addr = 32'h0000_7000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_addr = (k % 2 == 0) ? 32'h0000_6000 : 32'h0000_7000;
            n_cmp++; if (ram_en !== 1'b1 || ram_addr !== exp_addr) begin
                n_bad++; $display("FAIL cont_grant_%0d got en=%b addr=%h want 1 %h", k, ram_en, ram_addr, exp_addr);
            end
            ram_rdata = 32'hC0DE_0000 + k; ram_ack = 1'b1;
            @(negedge clk);
            ram_ack = 1'b0;
            if (k % 2 == 0) begin
                n_cmp++; if (d_ready !== 1'b1 || if_ready !== 1'b0 || d_rdata !== 32'hC0DE_0000 + k) begin
                    n_bad++; $display("FAIL cont_data_%0d got drdy=%b irdy=%b rdata=%h", k, d_ready, if_ready, d_rdata);
                end
            end else begin
                n_cmp++; if (if_ready !== 1'b1 || d_ready !== 1'b0 || if_rdata !== 32'hC0DE_0000 + k) begin
                    n_bad++; $display("FAIL cont_fetch_%0d got irdy=%b drdy=%b rdata=%h", k, if_ready, d_ready, if_rdata);
                end
            end
        end
        d_read = 1'b0; if_req = 1'b0;
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b0) begin
            n_bad++; $display("FAIL cont_idle got en=%b want 0", ram_en);
        end
    endtask

    task automatic test_reset_mid();
        d_read = 1'b1; d_sel = 4'b1111; d_addr = 32'h0000_8000;
        @(negedge clk);
        n_cmp++; if (ram_en !== 1'b1) begin
            n_bad++; $display("FAIL rm_grant got en=%b want 1", ram_en);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ram_en !== 1'b0 || ram_addr !== 32'h0 || d_ready !== 1'b0) begin
            n_bad++; $display("FAIL rm_async got en=%b addr=%h rdy=%b want 0 0 0", ram_en, ram_addr, d_ready);
        end
        d_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ram_rdata = 32'hBAD0_BAD0; ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        n_cmp++; if (d_ready !== 1'b0 || if_ready !== 1'b0 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rm_late_ack got rdy=%b irdy=%b rdata=%h want 0 0 0", d_ready, if_ready, d_rdata);
        end
        @(negedge clk);
        n_cmp++; if (d_ready !== 1'b0 || ram_en !== 1'b0) begin
            n_bad++; $display("FAIL rm_quiet got rdy=%b en=%b want 0 0", d_ready, ram_en);
        end
    endtask

    initial begin
        test_reset();
        test_byte_store();
        test_word_load();
        test_idle_ack();
        test_illegal();
        test_halfword();
        test_fetch();
        test_contention();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
